avl_bus_slave_mem: RTL and testbench

Synthesizable Avalon-style bus slave (responder) backed by an internal word-addressed RAM. It accepts single and burst read/write commands from the bus interconnect and applies byte-lane writes. Read data returns in order through a response FIFO that honours master backpressure (resp_ready). It also checks the burst protocol and keeps access statistics, so it serves as the slave endpoint in bus interconnect testbenches and as a scratch memory in the design.

---
 rtl/avl_bus_slave_mem.sv | 136 +++++++++++++
 tb/tb_avl_bus_slave_mem.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_bus_slave_mem.sv
// Avalon-style bus slave backed by a word-addressed RAM, with an in-order read
// response FIFO, burst protocol checking and access counters.
module avl_bus_slave_mem #(
    parameter int unsigned MEM_ADDR_W      = 10,
    parameter int unsigned RESP_FIFO_DEPTH = 4,
    parameter int unsigned BURST_W         = 8
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        address,
    input  logic [3:0]         byte_en,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        write_data,
    input  logic               begin_burst_transfer,
    input  logic [BURST_W-1:0] burst_count,
    output logic               request_ready,
    output logic [31:0]        read_data,
    output logic               read_data_valid,
    input  logic               resp_ready,
    output logic               proto_err,
    output logic [31:0]        rd_cnt,
    output logic [31:0]        wr_cnt
);

    localparam int unsigned DEPTH = 1 << MEM_ADDR_W;
    localparam int unsigned PW    = $clog2(RESP_FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_ram_q;
    logic                  r_rd_pend;
    logic [31:0]           r_fifo [RESP_FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_wr_cnt;
    state_t                r_state;
    logic                  r_burst_wr;
    logic [MEM_ADDR_W-1:0] r_exp_idx;
    logic [BURST_W-1:0]    r_exp_cnt;
    logic                  r_proto_err;

    logic [MEM_ADDR_W-1:0] w_idx;
    logic [CW-1:0]         w_outstanding;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused_addr;

    assign w_idx         = address[MEM_ADDR_W+1:2];
    assign w_unused_addr = ^{address[31:MEM_ADDR_W+2], address[1:0]};

    // Credits cover both queued responses and the read still in the RAM pipeline.
    assign w_outstanding = r_count + CW'(r_rd_pend);
    assign request_ready = !rest && (w_outstanding < CW'(RESP_FIFO_DEPTH));
    assign w_acc         = request_ready && (read || write);
    assign w_wr          = w_acc && write;
    assign w_rd          = w_acc && read && !write;
    assign w_push        = r_rd_pend;
    assign w_pop         = read_data_valid && resp_ready;

    assign read_data_valid = (r_count != '0);
    assign read_data       = read_data_valid ? r_fifo[r_rd_ptr] : 32'h0;
    assign proto_err       = r_proto_err;
    assign rd_cnt          = r_rd_cnt;
    assign wr_cnt          = r_wr_cnt;

    // Storage without reset: RAM, its registered read port and FIFO entries.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) r_mem[w_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
        if (w_rd) r_ram_q <= r_mem[w_idx];
        if (w_push) r_fifo[r_wr_ptr] <= r_ram_q;
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            r_rd_pend <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_cnt  <= 32'h0;
            r_wr_cnt  <= 32'h0;
        end else begin
            r_rd_pend <= w_rd;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_rd) r_rd_cnt <= r_rd_cnt + 32'h1;
            if (w_wr) r_wr_cnt <= r_wr_cnt + 32'h1;
        end
    end

    // Burst tracker; addresses are compared as RAM word indices so wrap is legal.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_state     <= S_IDLE;
            r_burst_wr  <= 1'b0;
            r_exp_idx   <= '0;
            r_exp_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else if (w_acc) begin
            if (read && write) r_proto_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (begin_burst_transfer && (burst_count != '0)) begin
                        r_state    <= S_BURST;
                        r_burst_wr <= write;
                        r_exp_idx  <= w_idx + MEM_ADDR_W'(1);
                        r_exp_cnt  <= burst_count - BURST_W'(1);
                    end
                end
                S_BURST: begin
                    if (begin_burst_transfer || (write != r_burst_wr) ||
                        (w_idx != r_exp_idx) || (burst_count != r_exp_cnt)) begin
                        r_proto_err <= 1'b1;
                    end
                    r_exp_idx <= r_exp_idx + MEM_ADDR_W'(1);
                    r_exp_cnt <= r_exp_cnt - BURST_W'(1);
                    if (burst_count == '0) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avl_bus_slave_mem.sv
// Self-checking bench for avl_bus_slave_mem: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a transaction model.
module tb_avl_bus_slave_mem;

    localparam int unsigned MAW = 10;
    localparam int unsigned FD  = 4;
    localparam int unsigned BW  = 8;
    localparam int unsigned NW  = 1 << MAW;

    logic          clk = 1'b0;
    logic          rest;
    logic [31:0]   address;
    logic [3:0]    byte_en;
    logic          read;
    logic          write;
    logic [31:0]   write_data;
    logic          begin_burst_transfer;
    logic [BW-1:0] burst_count;
    logic          request_ready;
    logic [31:0]   read_data;
    logic          read_data_valid;
    logic          resp_ready;
    logic          proto_err;
    logic [31:0]   rd_cnt;
    logic [31:0]   wr_cnt;

    always #5 clk = ~clk;

    avl_bus_slave_mem #(.MEM_ADDR_W(MAW), .RESP_FIFO_DEPTH(FD), .BURST_W(BW)) dut (
        .clk(clk), .rest(rest), .address(address), .byte_en(byte_en),
        .read(read), .write(write), .write_data(write_data),
        .begin_burst_transfer(begin_burst_transfer), .burst_count(burst_count),
        .request_ready(request_ready), .read_data(read_data),
        .read_data_valid(read_data_valid), .resp_ready(resp_ready),
        .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic        bb;
        logic [7:0]  cnt;
        logic        rr;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
        int          rdy;
    } rsp_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction-level model: byte-granular memory, timed response queue, burst expectation.
    logic [7:0]  m_b [NW*4];
    bit          m_k [NW*4];
    rsp_t        m_q [$];
    logic [31:0] m_rc, m_wc;
    bit          m_err, m_inb, m_bwr;
    int          m_nidx;
    logic [7:0]  m_left;

    logic        s_rdy, s_vld, s_err;
    logic [31:0] s_data, s_rc, s_wc;
    bit          last_acc, last_pop;

    vec_t tv [23];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e,
                       input logic [31:0] m);
        n_chk++;
        if ((a & m) !== (e & m)) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic cmd_t mk(bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                                logic [3:0] be, bit bb, logic [7:0] cnt, bit rr);
        cmd_t c;
        c.rst = 1'b0; c.addr = a; c.be = be; c.rd = rd; c.wr = wr;
        c.wd = d; c.bb = bb; c.cnt = cnt; c.rr = rr;
        return c;
    endfunction

    function automatic cmd_t idle(bit rr);
        return mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'h0, rr);
    endfunction

    task automatic setv(input int i, input cmd_t c, input bit r, input bit v,
                        input logic [31:0] d, input bit e);
        tv[i].c = c; tv[i].e_rdy = r; tv[i].e_vld = v; tv[i].e_data = d; tv[i].e_err = e;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rc = 32'h0; m_wc = 32'h0;
        m_err = 1'b0; m_inb = 1'b0; m_bwr = 1'b0; m_nidx = 0; m_left = 8'h0;
    endtask

    // One bus cycle: drive, compare against the model, advance the model and the clock.
    task automatic step(input cmd_t c);
        bit   e_rdy, e_vld;
        int   widx;
        rsp_t r;
        rest = c.rst; address = c.addr; byte_en = c.be; read = c.rd; write = c.wr;
        write_data = c.wd; begin_burst_transfer = c.bb; burst_count = c.cnt; resp_ready = c.rr;
        #1;
        e_rdy = !c.rst && (m_q.size() < FD);
        e_vld = (m_q.size() > 0) && (m_q[0].rdy <= cyc);
        s_rdy = request_ready; s_vld = read_data_valid; s_data = read_data;
        s_err = proto_err; s_rc = rd_cnt; s_wc = wr_cnt;
        chk("request_ready", 32'(request_ready), 32'(e_rdy), 32'h1);
        chk("read_data_valid", 32'(read_data_valid), 32'(e_vld), 32'h1);
        if (e_vld) chk("read_data", read_data, m_q[0].d, m_q[0].m);
        chk("proto_err", 32'(proto_err), 32'(m_err), 32'h1);
        chk("rd_cnt", rd_cnt, m_rc, 32'hFFFF_FFFF);
        chk("wr_cnt", wr_cnt, m_wc, 32'hFFFF_FFFF);

        last_acc = e_rdy && (c.rd || c.wr);
        last_pop = e_vld && c.rr;
        if (last_pop) void'(m_q.pop_front());
        if (last_acc) begin
            widx = int'((c.addr / 4) % NW);
            if (c.wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (c.be[i]) begin
                        m_b[widx*4+i] = c.wd[8*i +: 8];
                        m_k[widx*4+i] = 1'b1;
                    end
                end
                m_wc = m_wc + 32'h1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    r.d[8*i +: 8] = m_b[widx*4+i];
                    r.m[8*i +: 8] = m_k[widx*4+i] ? 8'hFF : 8'h00;
                end
                r.rdy = cyc + 2;
                m_q.push_back(r);
                m_rc = m_rc + 32'h1;
            end
            if (c.rd && c.wr) m_err = 1'b1;
            if (!m_inb) begin
                if (c.bb && c.cnt != 8'h0) begin
                    m_inb = 1'b1; m_bwr = c.wr;
                    m_nidx = (widx + 1) % NW; m_left = c.cnt - 8'h1;
                end
            end else begin
                if (c.bb || (c.wr != m_bwr) || (widx != m_nidx) || (c.cnt != m_left))
                    m_err = 1'b1;
                m_nidx = (m_nidx + 1) % NW;
                m_left = m_left - 8'h1;
                if (c.cnt == 8'h0) m_inb = 1'b0;
            end
        end
        if (c.rst) model_reset();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Hold a command until accepted, bounded.
    task automatic issue(input cmd_t c, input string nm);
        int n = 0;
        do begin
            step(c);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) begin
            n_chk++; n_err++;
            $display("FAIL %s: command not accepted within 20 cycles", nm);
        end
    endtask

    initial begin
        cmd_t cur, rc;
        bit   hold;
        int   gb_left, k, npop, sel;
        logic [31:0] gb_addr, a, pops [6];
        bit   gb_wr;

        // Directed table: outputs listed are those seen in the same cycle the inputs are driven.
        setv(0,  mk(0,1,32'h10,32'hA5A5_1234,4'hF,0,0,1), 1,0,32'h0,0);
        setv(1,  mk(1,0,32'h10,32'h0,4'hF,0,0,1),         1,0,32'h0,0);
        setv(2,  idle(1),                                  1,0,32'h0,0);
        setv(3,  idle(1),                                  1,1,32'hA5A5_1234,0);
        setv(4,  mk(0,1,32'h20,32'hFFFF_FFFF,4'hF,0,0,1), 1,0,32'h0,0);
        setv(5,  mk(0,1,32'h20,32'h0000_0000,4'h3,0,0,1), 1,0,32'h0,0);
        setv(6,  mk(1,0,32'h20,32'h0,4'h0,0,0,1),         1,0,32'h0,0);
        setv(7,  idle(1),                                  1,0,32'h0,0);
        setv(8,  idle(1),                                  1,1,32'hFFFF_0000,0);
        setv(9,  mk(0,1,32'h40,32'h11,4'hF,1,3,1),        1,0,32'h0,0);
        setv(10, mk(0,1,32'h44,32'h22,4'hF,0,2,1),        1,0,32'h0,0);
        setv(11, mk(0,1,32'h48,32'h33,4'hF,0,1,1),        1,0,32'h0,0);
        setv(12, mk(0,1,32'h4C,32'h44,4'hF,0,0,1),        1,0,32'h0,0);
        setv(13, mk(1,0,32'h40,32'h0,4'hF,0,0,1),         1,0,32'h0,0);
        setv(14, mk(1,0,32'h4C,32'h0,4'hF,0,0,1),         1,0,32'h0,0);
        setv(15, idle(1),                                  1,1,32'h11,0);
        setv(16, idle(1),                                  1,1,32'h44,0);
        setv(17, mk(0,1,32'h80,32'h55,4'hF,1,2,1),        1,0,32'h0,0);
        setv(18, mk(0,1,32'h88,32'h66,4'hF,0,1,1),        1,0,32'h0,0);
        setv(19, idle(1),                                  1,0,32'h0,1);
        setv(20, mk(1,0,32'h88,32'h0,4'hF,0,0,1),         1,0,32'h0,1);
        setv(21, idle(1),                                  1,0,32'h0,1);
        setv(22, idle(1),                                  1,1,32'h66,1);

        rest = 1'b1; address = 32'h0; byte_en = 4'h0; read = 1'b0; write = 1'b0;
        write_data = 32'h0; begin_burst_transfer = 1'b0; burst_count = 8'h0; resp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rest = 1'b0;

        for (int i = 0; i < 23; i++) begin
            step(tv[i].c);
            chk($sformatf("vec%0d_ready", i), 32'(s_rdy), 32'(tv[i].e_rdy), 32'h1);
            chk($sformatf("vec%0d_valid", i), 32'(s_vld), 32'(tv[i].e_vld), 32'h1);
            if (tv[i].e_vld) chk($sformatf("vec%0d_data", i), s_data, tv[i].e_data, 32'hFFFF_FFFF);
            chk($sformatf("vec%0d_err", i), 32'(s_err), 32'(tv[i].e_err), 32'h1);
            if (i == 2) begin
                chk("t1_rd_cnt", s_rc, 32'd1, 32'hFFFF_FFFF);
                chk("t1_wr_cnt", s_wc, 32'd1, 32'hFFFF_FFFF);
            end
        end

        // Backpressure: only FD reads may be outstanding.
        for (int i = 0; i < 6; i++)
            issue(mk(0,1,32'h100 + 32'(4*i),32'hC0DE_0000 + 32'(i),4'hF,0,0,1), "bp_prefill");
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step(mk(1,0,32'h100 + 32'(4*k),32'h0,4'hF,0,0,0));
            if (last_acc) k++;
        end
        chk("bp_accepted", 32'(k), 32'd4, 32'hFFFF_FFFF);
        chk("bp_ready_low", 32'(s_rdy), 32'd0, 32'h1);
        npop = 0;
        for (int i = 0; i < 40 && npop < 6; i++) begin
            if (k < 6) step(mk(1,0,32'h100 + 32'(4*k),32'h0,4'hF,0,0,1));
            else step(idle(1));
            if (last_acc) k++;
            if (last_pop) begin
                pops[npop] = s_data;
                npop++;
            end
        end
        chk("bp_pop_count", 32'(npop), 32'd6, 32'hFFFF_FFFF);
        for (int i = 0; i < npop; i++)
            chk($sformatf("bp_order%0d", i), pops[i], 32'hC0DE_0000 + 32'(i), 32'hFFFF_FFFF);

        // Reset with responses queued and a burst open.
        issue(mk(0,1,32'h200,32'h600D_F00D,4'hF,0,0,0), "rst_prefill");
        for (int i = 0; i < 3; i++) issue(mk(1,0,32'h200,32'h0,4'hF,0,0,0), "rst_reads");
        issue(mk(0,1,32'h300,32'h1234_5678,4'hF,1,5,0), "rst_burst");
        step(idle(0));
        step(idle(0));
        chk("rst_pre_valid", 32'(s_vld), 32'd1, 32'h1);
        rc = idle(0); rc.rst = 1'b1;
        step(rc);
        step(idle(1));
        chk("rst_valid", 32'(s_vld), 32'd0, 32'h1);
        chk("rst_rd_cnt", s_rc, 32'd0, 32'hFFFF_FFFF);
        chk("rst_wr_cnt", s_wc, 32'd0, 32'hFFFF_FFFF);
        chk("rst_err", 32'(s_err), 32'd0, 32'h1);
        step(mk(1,0,32'h200,32'h0,4'hF,0,0,1));
        step(idle(1));
        step(idle(1));
        chk("rst_ram_valid", 32'(s_vld), 32'd1, 32'h1);
        chk("rst_ram_data", s_data, 32'h600D_F00D, 32'hFFFF_FFFF);
        chk("rst_ram_err", 32'(s_err), 32'd0, 32'h1);

        // Randomized traffic: singles, bursts (occasionally broken), read+write, resets.
        hold = 1'b0; gb_left = -1; gb_addr = 32'h0; gb_wr = 1'b0; cur = idle(1);
        for (int n = 0; n < 1500; n++) begin
            if (!hold) begin
                if (gb_left >= 0 && $urandom_range(0, 3) != 0) begin
                    a = gb_addr;
                    if ($urandom_range(0, 15) == 0) a = a + 32'h8;
                    cur = mk(!gb_wr, gb_wr, a, $urandom, 4'($urandom), 0, 8'(gb_left), 1);
                    gb_addr = gb_addr + 32'h4;
                    gb_left--;
                end else if (gb_left >= 0) begin
                    cur = idle(1);
                end else begin
                    a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) * 4
                                                    : 32'(1008 + $urandom_range(0, 15)) * 4;
                    a = a + 32'($urandom_range(0, 3)) * 32'h1000;
                    sel = $urandom_range(0, 9);
                    if (sel <= 2) cur = idle(1);
                    else if (sel <= 5) cur = mk(1, 0, a, 32'h0, 4'($urandom), 0, 0, 1);
                    else if (sel <= 7) cur = mk(0, 1, a, $urandom, 4'($urandom), 0, 0, 1);
                    else if (sel == 8) begin
                        gb_wr = ($urandom_range(0, 1) == 1);
                        gb_left = $urandom_range(1, 4);
                        cur = mk(!gb_wr, gb_wr, a, $urandom, 4'($urandom), 1, 8'(gb_left), 1);
                        gb_addr = a + 32'h4;
                        gb_left--;
                    end else cur = mk(1, 1, a, $urandom, 4'($urandom), 0, 0, 1);
                end
            end
            cur.rr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rc = cur; rc.rst = 1'b1;
                step(rc);
                hold = 1'b0; gb_left = -1;
            end else begin
                step(cur);
                hold = (cur.rd || cur.wr) && !last_acc;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
